// File: rtl/input_pkg.sv
// Shared definitions for the mechanical-input conditioning blocks.
//   btn_state_t : debounce FSM state encoding
//   cnt_width() : counter width that can hold max(a, b) inclusive
package input_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } btn_state_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/button_events_if.sv
// Signal bundle between an input synchronizer and the button_events stage.
//   sync_in    : synchronized raw input
//   level      : debounced level
//   press      : one-cycle pulse on level 0->1
//   released   : one-cycle pulse on level 1->0 ("release" is a reserved word)
//   long_press : one-cycle pulse once a press has been held long enough
// master drives sync_in and observes events; slave is the debouncer.
interface button_events_if;
  logic sync_in;
  logic level;
  logic press;
  logic released;
  logic long_press;

  modport master (
    output sync_in,
    input  level, press, released, long_press
  );

  modport slave (
    input  sync_in,
    output level, press, released, long_press
  );
endinterface

// File: rtl/button_events.sv
// Debounce and event extraction for one synchronized mechanical input.
// A level change is accepted after DEBOUNCE_CYCLES consecutive samples of
// the new value; press/release/long-press are registered one-cycle pulses.
// Ports:
//   clk   : sole clock, posedge
//   reset : asynchronous active-low reset
//   bus   : button_events_if.slave (sync_in in; level and pulses out)
//
// state    | meaning
// LOW      | level = 0, waiting for a 1
// CHK_HIGH | candidate rise, counting consecutive 1s
// HIGH     | level = 1, hold timer running
// CHK_LOW  | candidate fall, level still 1, hold timer still running
module button_events
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic            clk,
  input  logic            reset,
  button_events_if.slave  bus
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CNT_W-1:0] D_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] H_TC  = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] H_SAT = CNT_W'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("button_events: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  btn_state_t       state;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_inc;
  logic             hcnt_tc;
  logic             level_q, press_q, released_q, long_q;

  // Hold timer saturates at LONG_CYCLES so the terminal count is crossed once.
  always_comb begin
    hcnt_inc = (hcnt == H_SAT) ? hcnt : hcnt + 1'b1;
    hcnt_tc  = (hcnt == H_TC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOW;
      dcnt       <= '0;
      hcnt       <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      released_q <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      press_q    <= 1'b0;
      released_q <= 1'b0;
      long_q     <= 1'b0;
      case (state)
        LOW: begin
          if (bus.sync_in) begin
            state <= CHK_HIGH;
            dcnt  <= CNT_W'(1);
          end
        end
        CHK_HIGH: begin
          if (!bus.sync_in) begin
            state <= LOW;
            dcnt  <= '0;
          end else if (dcnt == D_TC) begin
            state   <= HIGH;
            level_q <= 1'b1;
            press_q <= 1'b1;
            hcnt    <= '0;
            dcnt    <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        HIGH: begin
          hcnt   <= hcnt_inc;
          long_q <= hcnt_tc;
          if (!bus.sync_in) begin
            state <= CHK_LOW;
            dcnt  <= CNT_W'(1);
          end
        end
        CHK_LOW: begin
          // Release takes priority over a coincident long-press terminal count.
          if (!bus.sync_in && dcnt == D_TC) begin
            state      <= LOW;
            level_q    <= 1'b0;
            released_q <= 1'b1;
            hcnt       <= '0;
            dcnt       <= '0;
          end else begin
            hcnt   <= hcnt_inc;
            long_q <= hcnt_tc;
            if (bus.sync_in) begin
              state <= HIGH;
              dcnt  <= '0;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= LOW;
          dcnt  <= '0;
          hcnt  <= '0;
        end
      endcase
    end
  end

  assign bus.level      = level_q;
  assign bus.press      = press_q;
  assign bus.released   = released_q;
  assign bus.long_press = long_q;

endmodule
